multi_key_debouncer: RTL and testbench
======================================

Name: multi_key_debouncer

Overview:
- Parametrised N-channel push-button debouncer and edge detector for the board key inputs (game controls, menu keys).
- Each channel has its own input synchroniser, stability counter and debounced level.
- Each channel emits one-cycle press and release pulses, plus optional hold-to-auto-repeat pulses.
- Feeds the game/control FSMs directly; no bus interface.

Parameters:
- N_KEYS, 4, number of independent key channels (1..16)
- DEBOUNCE_CYC, 250000, consecutive cycles a new level must persist before it is accepted (>=2)
- ACTIVE_LOW, 1, 1: key_in low = pressed; 0: key_in high = pressed
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (used only with KEY_REPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (used only with KEY_REPEAT_EN)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  N_KEYS  raw asynchronous key pins
- key_state  output  N_KEYS  debounced level, 1 = pressed
- key_press  output  N_KEYS  one-cycle pulse on accepted press
- key_release  output  N_KEYS  one-cycle pulse on accepted release
- key_repeat  output  N_KEYS  one-cycle auto-repeat pulse while held
- key_event  output  N_KEYS  key_press | key_repeat, registered

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All flops reset on negedge rst_n and are otherwise updated only on posedge clk.
- Internal counter widths: $clog2(max(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)+1). No wrap is allowed.
- Reset values:
  - Sync flops hold the released level (ACTIVE_LOW=1: 1; else 0).
  - Counters = 0.
  - All outputs = 0 (released, no pulses).
- Per channel, independent of the others:
  - 2-flop synchroniser, then polarity normalise to raw_p (1 = pressed).
  - raw_p == key_state: stability counter cleared to 0.
  - raw_p != key_state: counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 and raw_p still differs, key_state toggles on that edge and the counter clears.
  - Any single cycle of raw_p == key_state before that point restarts the count from 0 (glitch rejection).
- Latency:
  - A clean level change first sampled at edge E0 sets key_state at edge E0+DEBOUNCE_CYC+1 (2 sync stages plus DEBOUNCE_CYC counting cycles).
  - key_press/key_release assert in the same cycle key_state changes, for exactly 1 cycle.
- key_press and key_release never assert together on one channel. Multiple channels may pulse in the same cycle.
- A key held through reset deassertion is seen as a new press: a press pulse follows after the debounce latency.
- Reset mid-count discards all progress. No pulse is generated by reset itself.
- key_event is key_press | key_repeat, registered in the same cycle as its sources (no added latency).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, cleared whenever key_state = 0 and on key_press.
  - While key_state = 1, the counter counts. The first key_repeat asserts REPEAT_DELAY cycles after the key_press cycle; subsequent pulses follow every REPEAT_PERIOD cycles.
  - Release (key_state falls) cancels immediately: no repeat in or after the release cycle.
  - key_repeat never coincides with key_press.
- Undefined: no repeat logic is synthesised, key_repeat is tied 0, and key_event equals key_press.

Test Plan:
- Reset/defaults (DEBOUNCE_CYC=8, N_KEYS=4, ACTIVE_LOW=1): all key_in=1, release rst_n -> all outputs 0 indefinitely; key_in[0]=0 held at rst_n release -> key_press[0] single pulse 9 edges after first sample.
- Clean press/release on key 1: key_in[1] 1->0 held 20 cycles -> key_state[1] rises at E0+9 with key_press[1] 1-cycle pulse; back to 1 -> key_release[1] pulse at E0'+9, key_state[1]=0.
- Glitch rejection on key 2: key_in[2] low 7 cycles, high 1, low 7 -> no pulse, key_state[2] stays 0; then low 8+ cycles -> exactly one key_press[2].
- Simultaneous channels: keys 0 and 3 pressed on the same edge -> key_press=4'b1001 in one cycle; mid-count rst_n pulse -> counters restart, no output until a full 9 edges after reset release.
- KEY_REPEAT_EN with REPEAT_DELAY=20, REPEAT_PERIOD=5: hold key 0 for 40 cycles after press -> key_repeat[0] at press+20, +25, +30, +35; release -> no further repeats; key_event[0] = 5 pulses total.
- KEY_REPEAT_EN undefined, same stimulus -> key_repeat = 0 throughout, key_event[0] single pulse.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// N-channel key debouncer with press/release edge pulses and optional auto-repeat.
// Optional auto-repeat logic is built only when KEY_REPEAT_EN is defined.
module multi_key_debouncer #(
  parameter int N_KEYS        = 4,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_event
);

  localparam int MAX_DR  = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [N_KEYS-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] raw_p;
  logic [CNT_W-1:0]  db_cnt     [N_KEYS];
  logic [CNT_W-1:0]  db_cnt_nxt [N_KEYS];
  logic [N_KEYS-1:0] state_nxt;
  logic [N_KEYS-1:0] press_nxt;
  logic [N_KEYS-1:0] release_nxt;
  logic [N_KEYS-1:0] repeat_nxt;

  // Stage p0/p1: two-flop synchroniser, idle at the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= REL_LVL;
      sync_p1 <= REL_LVL;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  assign raw_p = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // Stability counting: any cycle agreeing with key_state restarts the count
  always_comb begin
    state_nxt   = key_state;
    press_nxt   = '0;
    release_nxt = '0;
    db_cnt_nxt  = db_cnt;
    for (int i = 0; i < N_KEYS; i++) begin
      if (raw_p[i] == key_state[i]) begin
        db_cnt_nxt[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        db_cnt_nxt[i]  = '0;
        state_nxt[i]   = raw_p[i];
        press_nxt[i]   = raw_p[i];
        release_nxt[i] = ~raw_p[i];
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      db_cnt <= db_cnt_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0]  rpt_cnt     [N_KEYS];
  logic [CNT_W-1:0]  rpt_cnt_nxt [N_KEYS];
  logic [N_KEYS-1:0] rpt_phase;
  logic [N_KEYS-1:0] rpt_phase_nxt;

  // Repeat timing keys off the next key_state so a release edge suppresses its own pulse
  always_comb begin
    repeat_nxt    = '0;
    rpt_cnt_nxt   = rpt_cnt;
    rpt_phase_nxt = rpt_phase;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!state_nxt[i] || press_nxt[i]) begin
        rpt_cnt_nxt[i]   = '0;
        rpt_phase_nxt[i] = 1'b0;
      end else if (rpt_cnt[i] == (rpt_phase[i] ? RP_LAST : RD_LAST)) begin
        rpt_cnt_nxt[i]   = '0;
        rpt_phase_nxt[i] = 1'b1;
        repeat_nxt[i]    = 1'b1;
      end else begin
        rpt_cnt_nxt[i] = rpt_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) rpt_cnt[i] <= '0;
      rpt_phase <= '0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_phase <= rpt_phase_nxt;
    end
  end
`else
  assign repeat_nxt = '0;
`endif

  // Stage p2: registered outputs, all updated on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_repeat  <= '0;
      key_event   <= '0;
    end else begin
      key_state   <= state_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_repeat  <= repeat_nxt;
      key_event   <= press_nxt | repeat_nxt;
    end
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer (DEBOUNCE_CYC=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_multi_key_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic [3:0] key_event;

  int n_tests;
  int n_fail;

  logic [3:0] stim      [0:127];
  logic [3:0] cap_state [0:127];
  logic [3:0] cap_press [0:127];
  logic [3:0] cap_rel   [0:127];
  logic [3:0] cap_rpt   [0:127];
  logic [3:0] cap_evt   [0:127];

  multi_key_debouncer #(
    .N_KEYS(4), .DEBOUNCE_CYC(8), .ACTIVE_LOW(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .key_event(key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running, need finished");
    $fatal(1);
  end

  // Hold reset with the given pins, then release 1 ns after a rising edge.
  task automatic do_reset(input logic [3:0] pins);
    rst_n  = 1'b0;
    key_in = pins;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({key_state, key_press, key_release, key_repeat, key_event} !== 20'h0) begin
      n_fail++;
      $display("FAIL in_reset_outputs: got %h need 0",
               {key_state, key_press, key_release, key_repeat, key_event});
    end
    rst_n = 1'b1;
  endtask

  // Entry i: stim[i] is sampled on edge i, outputs captured 1 ns after edge i.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      key_in = stim[i];
      @(posedge clk);
      #1;
      cap_state[i] = key_state;
      cap_press[i] = key_press;
      cap_rel[i]   = key_release;
      cap_rpt[i]   = key_repeat;
      cap_evt[i]   = key_event;
    end
  endtask

  task automatic test_reset;
    int bad;
    logic [3:0] exp_p, exp_s;
    do_reset(4'hF);
    for (int i = 0; i < 30; i++) stim[i] = 4'hF;
    capture(30);
    bad = 0;
    for (int i = 0; i < 30; i++)
      if ({cap_state[i], cap_press[i], cap_rel[i], cap_rpt[i], cap_evt[i]} !== 20'h0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %0d nonzero cycles need 0", bad);
    end
    // key 0 held down through reset release
    do_reset(4'hE);
    for (int i = 0; i < 20; i++) stim[i] = 4'hE;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      exp_p = (i == 9) ? 4'b0001 : 4'b0000;
      exp_s = (i >= 9) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (cap_press[i] !== exp_p || cap_state[i] !== exp_s || cap_rel[i] !== 4'h0) begin
        n_fail++;
        $display("FAIL held_through_reset[%0d]: got press=%b state=%b rel=%b need press=%b state=%b rel=0000",
                 i, cap_press[i], cap_state[i], cap_rel[i], exp_p, exp_s);
      end
    end
  endtask

  task automatic test_clean_press_release;
    logic [3:0] exp_p, exp_r, exp_s;
    do_reset(4'hF);
    for (int i = 0; i < 40; i++) stim[i] = (i < 20) ? 4'hD : 4'hF;
    capture(40);
    for (int i = 0; i < 40; i++) begin
      exp_p = (i == 9)  ? 4'b0010 : 4'b0000;
      exp_r = (i == 29) ? 4'b0010 : 4'b0000;
      exp_s = (i >= 9 && i < 29) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (cap_press[i] !== exp_p || cap_rel[i] !== exp_r || cap_state[i] !== exp_s) begin
        n_fail++;
        $display("FAIL clean_key1[%0d]: got press=%b rel=%b state=%b need press=%b rel=%b state=%b",
                 i, cap_press[i], cap_rel[i], cap_state[i], exp_p, exp_r, exp_s);
      end
    end
  endtask

  task automatic test_glitch;
    logic [3:0] exp_p, exp_s;
    int presses;
    do_reset(4'hF);
    for (int i = 0; i < 45; i++) stim[i] = (i == 7 || i == 15) ? 4'hF : 4'hB;
    capture(45);
    presses = 0;
    for (int i = 0; i < 45; i++) begin
      if (cap_press[i][2]) presses++;
      exp_p = (i == 25) ? 4'b0100 : 4'b0000;
      exp_s = (i >= 25) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (cap_press[i] !== exp_p || cap_state[i] !== exp_s || cap_rel[i] !== 4'h0) begin
        n_fail++;
        $display("FAIL glitch_key2[%0d]: got press=%b state=%b rel=%b need press=%b state=%b rel=0000",
                 i, cap_press[i], cap_state[i], cap_rel[i], exp_p, exp_s);
      end
    end
    n_tests++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL glitch_press_count: got %0d need 1", presses);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp_p;
    do_reset(4'hF);
    for (int i = 0; i < 14; i++) stim[i] = 4'h6;
    capture(14);
    for (int i = 0; i < 14; i++) begin
      exp_p = (i == 9) ? 4'b1001 : 4'b0000;
      n_tests++;
      if (cap_press[i] !== exp_p) begin
        n_fail++;
        $display("FAIL simultaneous_press[%0d]: got %b need %b", i, cap_press[i], exp_p);
      end
    end
  endtask

  task automatic test_mid_count_reset;
    logic [3:0] exp_p, exp_s;
    do_reset(4'hF);
    for (int i = 0; i < 6; i++) stim[i] = 4'hD;
    capture(6);
    do_reset(4'hD);
    for (int i = 0; i < 14; i++) stim[i] = 4'hD;
    capture(14);
    for (int i = 0; i < 14; i++) begin
      exp_p = (i == 9) ? 4'b0010 : 4'b0000;
      exp_s = (i >= 9) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (cap_press[i] !== exp_p || cap_state[i] !== exp_s) begin
        n_fail++;
        $display("FAIL mid_reset_key1[%0d]: got press=%b state=%b need press=%b state=%b",
                 i, cap_press[i], cap_state[i], exp_p, exp_s);
      end
    end
  endtask

  task automatic test_repeat;
    logic [3:0] exp_rpt, exp_evt, exp_s, exp_r;
    int events;
    int exp_events;
    do_reset(4'hF);
    for (int i = 0; i < 70; i++) stim[i] = (i < 40) ? 4'hE : 4'hF;
    capture(70);
    events = 0;
    for (int i = 0; i < 70; i++) begin
      if (cap_evt[i][0]) events++;
`ifdef KEY_REPEAT_EN
      exp_rpt = (i == 29 || i == 34 || i == 39 || i == 44) ? 4'b0001 : 4'b0000;
`else
      exp_rpt = 4'b0000;
`endif
      exp_evt = exp_rpt | ((i == 9) ? 4'b0001 : 4'b0000);
      exp_s   = (i >= 9 && i < 49) ? 4'b0001 : 4'b0000;
      exp_r   = (i == 49) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (cap_rpt[i] !== exp_rpt || cap_evt[i] !== exp_evt ||
          cap_state[i] !== exp_s || cap_rel[i] !== exp_r) begin
        n_fail++;
        $display("FAIL repeat_key0[%0d]: got rpt=%b evt=%b state=%b rel=%b need rpt=%b evt=%b state=%b rel=%b",
                 i, cap_rpt[i], cap_evt[i], cap_state[i], cap_rel[i], exp_rpt, exp_evt, exp_s, exp_r);
      end
    end
`ifdef KEY_REPEAT_EN
    exp_events = 5;
`else
    exp_events = 1;
`endif
    n_tests++;
    if (events != exp_events) begin
      n_fail++;
      $display("FAIL event_count: got %0d need %0d", events, exp_events);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    key_in  = 4'hF;
    test_reset();
    test_clean_press_release();
    test_glitch();
    test_simultaneous();
    test_mid_count_reset();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
